// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Holds the config FSM states, legal prescale values, FIFO entry and config layouts.
// Helper functions are pure combinational utilities.
package uart_rx_pkg;

  typedef enum logic {
    ACTIVE  = 1'b0,
    PENDING = 1'b1
  } cfg_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam int QUIET_W = 10;

  typedef struct packed {
    logic       stp_err;
    logic       par_err;
    logic [7:0] data;
  } frame_t;

  typedef struct packed {
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
  } rx_cfg_t;

  function automatic logic is_legal_prescale(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead frame FIFO with occupancy output; head is visible whenever rd_vld is high.
// Latency: a write is readable after the edge that stores it.
// Backpressure: a write into a full FIFO is dropped (wr_drop) unless a pop happens on the same edge.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_vld,
  input  frame_t                 wr_dat,
  output logic                   wr_drop,
  output logic                   rd_vld,
  input  logic                   rd_rdy,
  output frame_t                 rd_dat,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  frame_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full, pop, push;

  // Pointer and level update; a pop frees the slot a same-edge write needs when full
  always_comb begin
    full     = (level_q == FULL_LVL);
    pop      = (level_q != '0) && rd_rdy;
    push     = wr_vld && (!full || pop);
    wr_drop  = wr_vld && full && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array, no reset needed since reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign rd_vld = (level_q != '0);
  assign rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;
  assign level  = level_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver controller: quiet-line config apply, frame capture FIFO, error statistics.
// Latency: frame event at edge N is visible on rd_* after edge N+1; config applies one edge after quiet >= 11*Prescale.
// Backpressure: rd_valid/rd_ready host port; frames arriving at a full FIFO are lost and set overrun.
// Option UART_RX_DROP_ERR_FRAMES_EN: frames with parity/stop errors are counted but not queued.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int         DEPTH        = 8,
  parameter logic [5:0] DEF_PRESCALE = 6'd8,
  parameter logic       DEF_PAR_EN   = 1'b1,
  parameter logic       DEF_PAR_TYP  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_wr,
  input  logic [5:0]             cfg_prescale,
  input  logic                   cfg_par_en,
  input  logic                   cfg_par_typ,
  output logic                   cfg_pending,
  output logic                   cfg_err,
  output logic [5:0]             Prescale,
  output logic                   PAR_EN,
  output logic                   PAR_TYP,
  input  logic                   RX_IN,
  input  logic [7:0]             rx_p_data,
  input  logic                   rx_data_valid,
  input  logic                   rx_par_err,
  input  logic                   rx_stp_err,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [7:0]             rd_data,
  output logic                   rd_par_err,
  output logic                   rd_stp_err,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overrun,
  input  logic                   clr_stat,
  output logic [7:0]             par_err_cnt,
  output logic [7:0]             stp_err_cnt
);

  localparam rx_cfg_t DEF_CFG = '{prescale: DEF_PRESCALE, par_en: DEF_PAR_EN, par_typ: DEF_PAR_TYP};

  cfg_state_e         state_q, state_d;
  rx_cfg_t            shadow_q, shadow_d;
  rx_cfg_t            active_q, active_d;
  logic               cfg_err_q, cfg_err_d;
  logic [QUIET_W-1:0] quiet_q, quiet_d;
  logic [QUIET_W-1:0] quiet_thr;
  logic               cfg_legal, apply;

  logic               ev_or_q, ev_or_d;
  logic               frame_ev;
  logic               evt_vld_q, evt_vld_d;
  frame_t             evt_dat_q, evt_dat_d;
  logic               overrun_q, overrun_d;
  logic [7:0]         par_cnt_q, par_cnt_d;
  logic [7:0]         stp_cnt_q, stp_cnt_d;

  frame_t             head;
  logic               fifo_drop;

  // Threshold from the currently active prescale; 63*11 still fits in 10 bits
  assign quiet_thr = QUIET_W'(active_q.prescale) * QUIET_W'(11);

  // Config FSM: a new legal write always wins over a same-cycle apply
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    cfg_legal = is_legal_prescale(cfg_prescale);
    apply     = (state_q == PENDING) && (quiet_q >= quiet_thr);
    if (cfg_wr && cfg_legal) begin
      shadow_d = '{prescale: cfg_prescale, par_en: cfg_par_en, par_typ: cfg_par_typ};
      state_d  = PENDING;
    end else if (apply) begin
      active_d = shadow_q;
      state_d  = ACTIVE;
    end
  end

  // Quiet-line counter and sticky config error
  always_comb begin
    quiet_d   = quiet_q;
    cfg_err_d = cfg_err_q;
    if (!RX_IN)                    quiet_d = '0;
    else if (quiet_q != '1)        quiet_d = quiet_q + QUIET_W'(1);
    if (clr_stat)                  cfg_err_d = 1'b0;
    else if (cfg_wr && !cfg_legal) cfg_err_d = 1'b1;
  end

  // Frame event detection, capture stage and statistics
  always_comb begin
    ev_or_d   = rx_data_valid | rx_par_err | rx_stp_err;
    frame_ev  = ev_or_d && !ev_or_q;
    evt_dat_d = frame_ev ? frame_t'{stp_err: rx_stp_err, par_err: rx_par_err, data: rx_p_data}
                         : evt_dat_q;
`ifdef UART_RX_DROP_ERR_FRAMES_EN
    evt_vld_d = frame_ev && !rx_par_err && !rx_stp_err;
`else
    evt_vld_d = frame_ev;
`endif
    par_cnt_d = par_cnt_q;
    stp_cnt_d = stp_cnt_q;
    overrun_d = overrun_q;
    if (clr_stat) begin
      par_cnt_d = '0;
      stp_cnt_d = '0;
      overrun_d = 1'b0;
    end else begin
      if (frame_ev && rx_par_err) par_cnt_d = sat_inc8(par_cnt_q);
      if (frame_ev && rx_stp_err) stp_cnt_d = sat_inc8(stp_cnt_q);
      if (fifo_drop)              overrun_d = 1'b1;
    end
  end

  // All controller registers; reset discards any pending shadow and restores defaults
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ACTIVE;
      shadow_q  <= DEF_CFG;
      active_q  <= DEF_CFG;
      cfg_err_q <= 1'b0;
      quiet_q   <= '0;
      ev_or_q   <= 1'b0;
      evt_vld_q <= 1'b0;
      evt_dat_q <= '0;
      overrun_q <= 1'b0;
      par_cnt_q <= '0;
      stp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      cfg_err_q <= cfg_err_d;
      quiet_q   <= quiet_d;
      ev_or_q   <= ev_or_d;
      evt_vld_q <= evt_vld_d;
      evt_dat_q <= evt_dat_d;
      overrun_q <= overrun_d;
      par_cnt_q <= par_cnt_d;
      stp_cnt_q <= stp_cnt_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_vld  (evt_vld_q),
    .wr_dat  (evt_dat_q),
    .wr_drop (fifo_drop),
    .rd_vld  (rd_valid),
    .rd_rdy  (rd_ready),
    .rd_dat  (head),
    .level   (fifo_level)
  );

  assign cfg_pending = (state_q == PENDING);
  assign cfg_err     = cfg_err_q;
  assign Prescale    = active_q.prescale;
  assign PAR_EN      = active_q.par_en;
  assign PAR_TYP     = active_q.par_typ;
  assign rd_data     = head.data;
  assign rd_par_err  = head.par_err;
  assign rd_stp_err  = head.stp_err;
  assign overrun     = overrun_q;
  assign par_err_cnt = par_cnt_q;
  assign stp_err_cnt = stp_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed config/FIFO/statistics sequences plus
// a randomized frame stream compared against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_wr = 1'b0;
  logic [5:0] cfg_prescale = '0;
  logic       cfg_par_en = 1'b0;
  logic       cfg_par_typ = 1'b0;
  logic       cfg_pending, cfg_err;
  logic [5:0] Prescale;
  logic       PAR_EN, PAR_TYP;
  logic       RX_IN = 1'b1;
  logic [7:0] rx_p_data = '0;
  logic       rx_data_valid = 1'b0;
  logic       rx_par_err = 1'b0;
  logic       rx_stp_err = 1'b0;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_par_err, rd_stp_err;
  logic [3:0] fifo_level;
  logic       overrun;
  logic       clr_stat = 1'b0;
  logic [7:0] par_err_cnt, stp_err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DEPTH        (DEPTH),
    .DEF_PRESCALE (6'd8),
    .DEF_PAR_EN   (1'b1),
    .DEF_PAR_TYP  (1'b0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_wr        (cfg_wr),
    .cfg_prescale  (cfg_prescale),
    .cfg_par_en    (cfg_par_en),
    .cfg_par_typ   (cfg_par_typ),
    .cfg_pending   (cfg_pending),
    .cfg_err       (cfg_err),
    .Prescale      (Prescale),
    .PAR_EN        (PAR_EN),
    .PAR_TYP       (PAR_TYP),
    .RX_IN         (RX_IN),
    .rx_p_data     (rx_p_data),
    .rx_data_valid (rx_data_valid),
    .rx_par_err    (rx_par_err),
    .rx_stp_err    (rx_stp_err),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_par_err    (rd_par_err),
    .rd_stp_err    (rd_stp_err),
    .fifo_level    (fifo_level),
    .overrun       (overrun),
    .clr_stat      (clr_stat),
    .par_err_cnt   (par_err_cnt),
    .stp_err_cnt   (stp_err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cfg_wr = 1'b0; clr_stat = 1'b0; rd_ready = 1'b0; RX_IN = 1'b1;
    rx_data_valid = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0; rx_p_data = '0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  // One receiver frame: flags high for one cycle, then low, so the entry is queued on return
  task automatic frame(input logic [7:0] d, input logic pe, input logic se);
    rx_p_data = d; rx_par_err = pe; rx_stp_err = se; rx_data_valid = !(pe | se);
    tick();
    rx_data_valid = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [5:0] ps;
    logic       pe;
    logic       pt;
    logic       exp_err;
    logic       exp_pend;
  } cfg_vec_t;

  cfg_vec_t tbl [6];

  logic [7:0] drain_exp [8];
  logic       ok;

  // Reference model state for the randomized phase
  logic [9:0] mq [$];
  logic       m_prev, m_pend, m_ovr;
  logic [9:0] m_pend_dat;
  int         m_pc, m_sc;
  logic       or_now, ev;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    #1 rst = 1'b0;
    #2;
    check("rst_prescale", Prescale, 6'd8);
    check("rst_par_en",   PAR_EN, 1'b1);
    check("rst_par_typ",  PAR_TYP, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_level",    fifo_level, 4'd0);
    check("rst_pending",  cfg_pending, 1'b0);
    check("rst_cfg_err",  cfg_err, 1'b0);
    check("rst_overrun",  overrun, 1'b0);
    check("rst_cnts",     {par_err_cnt, stp_err_cnt}, 16'h0);
    tick();
    rst = 1'b1;
    tick();

    // ---------------- config apply on a quiet line ----------------
    RX_IN = 1'b0;
    tick();
    cfg_prescale = 6'd16; cfg_par_en = 1'b0; cfg_par_typ = 1'b1; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    check("pend_after_wr", cfg_pending, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      RX_IN = ((i / 20) % 2) == 0;
      tick();
      if (cfg_pending !== 1'b1) ok = 1'b0;
    end
    check("pend_held_while_busy", ok, 1'b1);
    check("prescale_old_busy", Prescale, 6'd8);
    RX_IN = 1'b1;
    repeat (88) tick();
    check("pend_at_quiet88", cfg_pending, 1'b1);
    check("prescale_at_quiet88", Prescale, 6'd8);
    tick();
    check("pend_after_apply", cfg_pending, 1'b0);
    check("prescale_applied", Prescale, 6'd16);
    check("par_en_applied", PAR_EN, 1'b0);
    check("par_typ_applied", PAR_TYP, 1'b1);

    // ---------------- table-driven config writes ----------------
    tbl[0] = '{ps: 6'd12, pe: 1'b1, pt: 1'b1, exp_err: 1'b1, exp_pend: 1'b0};
    tbl[1] = '{ps: 6'd0,  pe: 1'b0, pt: 1'b0, exp_err: 1'b1, exp_pend: 1'b0};
    tbl[2] = '{ps: 6'd63, pe: 1'b1, pt: 1'b0, exp_err: 1'b1, exp_pend: 1'b0};
    tbl[3] = '{ps: 6'd8,  pe: 1'b0, pt: 1'b0, exp_err: 1'b0, exp_pend: 1'b1};
    tbl[4] = '{ps: 6'd33, pe: 1'b0, pt: 1'b1, exp_err: 1'b1, exp_pend: 1'b1};
    tbl[5] = '{ps: 6'd32, pe: 1'b1, pt: 1'b1, exp_err: 1'b0, exp_pend: 1'b1};
    RX_IN = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      clr_stat = 1'b1;
      tick();
      clr_stat = 1'b0;
      check("tbl_clr_err", cfg_err, 1'b0);
      cfg_prescale = tbl[i].ps; cfg_par_en = tbl[i].pe; cfg_par_typ = tbl[i].pt; cfg_wr = 1'b1;
      tick();
      cfg_wr = 1'b0;
      check("tbl_cfg_err", cfg_err, tbl[i].exp_err);
      check("tbl_pending", cfg_pending, tbl[i].exp_pend);
      check("tbl_prescale_hold", Prescale, 6'd16);
    end
    // Threshold now uses the active prescale 16 -> 176; a write on the apply edge wins
    RX_IN = 1'b1;
    repeat (176) tick();
    check("pend_at_quiet176", cfg_pending, 1'b1);
    cfg_prescale = 6'd8; cfg_par_en = 1'b1; cfg_par_typ = 1'b0; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    check("wr_beats_apply_pend", cfg_pending, 1'b1);
    check("wr_beats_apply_ps", Prescale, 6'd16);
    tick();
    check("late_apply_pend", cfg_pending, 1'b0);
    check("late_apply_ps", Prescale, 6'd8);
    check("late_apply_par_en", PAR_EN, 1'b1);
    check("late_apply_par_typ", PAR_TYP, 1'b0);
    cfg_prescale = 6'd12; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    check("illegal_err", cfg_err, 1'b1);
    check("illegal_no_pend", cfg_pending, 1'b0);
    check("illegal_ps_hold", Prescale, 6'd8);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    check("clr_cfg_err", cfg_err, 1'b0);

    // ---------------- FIFO fill, overrun, push+pop while full ----------------
    rd_ready = 1'b0;
    rx_p_data = 8'h01; rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
    check("lat_edge_n", rd_valid, 1'b0);
    tick();
    check("lat_edge_n1", rd_valid, 1'b1);
    check("lat_head", rd_data, 8'h01);
    for (int i = 2; i <= 8; i++) frame(8'(i), 1'b0, 1'b0);
    check("full_level", fifo_level, 4'd8);
    check("full_no_ovr", overrun, 1'b0);
    frame(8'h09, 1'b0, 1'b0);
    check("ovr_level", fifo_level, 4'd8);
    check("ovr_set", overrun, 1'b1);
    check("ovr_head", rd_data, 8'h01);
    rx_p_data = 8'hA0; rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("pushpop_level", fifo_level, 4'd8);
    check("pushpop_head", rd_data, 8'h02);
    for (int i = 0; i < 7; i++) drain_exp[i] = 8'(i + 2);
    drain_exp[7] = 8'hA0;
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", rd_valid, 1'b1);
      check("drain_data", rd_data, drain_exp[i]);
      tick();
    end
    check("drained_valid", rd_valid, 1'b0);
    check("drained_level", fifo_level, 4'd0);
    tick();
    check("pop_empty_level", fifo_level, 4'd0);
    rd_ready = 1'b0;

    // ---------------- saturating counters, clr priority ----------------
    do_reset();
    for (int i = 0; i < 260; i++) frame(8'(i), 1'b1, 1'b1);
    check("sat_par", par_err_cnt, 8'd255);
    check("sat_stp", stp_err_cnt, 8'd255);
    check("err_head_flags", {rd_stp_err, rd_par_err, rd_data}, 10'h300);
    rx_par_err = 1'b1; rx_stp_err = 1'b1; clr_stat = 1'b1;
    tick();
    rx_par_err = 1'b0; rx_stp_err = 1'b0; clr_stat = 1'b0;
    check("clr_vs_ev_par", par_err_cnt, 8'd0);
    check("clr_vs_ev_stp", stp_err_cnt, 8'd0);
    check("clr_overrun", overrun, 1'b0);
    tick();
    check("clr_stays_par", par_err_cnt, 8'd0);

    // ---------------- randomized stream vs reference model ----------------
    do_reset();
    mq.delete();
    m_prev = 1'b0; m_pend = 1'b0; m_ovr = 1'b0; m_pend_dat = '0; m_pc = 0; m_sc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rx_data_valid = ($urandom % 3) == 0;
      rx_par_err    = ($urandom % 8) == 0;
      rx_stp_err    = ($urandom % 8) == 0;
      rx_p_data     = 8'($urandom);
      RX_IN         = 1'($urandom);
      clr_stat      = ($urandom % 64) == 0;
      rd_ready      = ((cyc / 400) % 2 == 0) ? (($urandom % 4) != 0) : (($urandom % 8) == 0);

      // Model: host pops first, then the frame captured last cycle enters if room remains
      if (rd_ready && mq.size() > 0) mq.delete(0);
      if (m_pend) begin
        if (mq.size() < DEPTH) mq.push_back(m_pend_dat);
        else m_ovr = 1'b1;
      end
      or_now = rx_data_valid | rx_par_err | rx_stp_err;
      ev     = or_now && !m_prev;
      if (clr_stat) begin
        m_pc = 0; m_sc = 0; m_ovr = 1'b0;
      end else begin
        if (ev && rx_par_err && m_pc < 255) m_pc++;
        if (ev && rx_stp_err && m_sc < 255) m_sc++;
      end
`ifdef UART_RX_DROP_ERR_FRAMES_EN
      m_pend = ev && !rx_par_err && !rx_stp_err;
`else
      m_pend = ev;
`endif
      if (ev) m_pend_dat = {rx_stp_err, rx_par_err, rx_p_data};
      m_prev = or_now;

      tick();
      check("rnd_valid", rd_valid, mq.size() > 0);
      check("rnd_level", fifo_level, mq.size());
      check("rnd_overrun", overrun, m_ovr);
      check("rnd_par_cnt", par_err_cnt, m_pc);
      check("rnd_stp_cnt", stp_err_cnt, m_sc);
      if (mq.size() > 0) check("rnd_head", {rd_stp_err, rd_par_err, rd_data}, mq[0]);
    end
    clr_stat = 1'b0; rd_ready = 1'b0;
    rx_data_valid = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
